// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch counting mm:ss.cc in BCD up to 59:59.99, advancing on each clk_div rising edge.
// The display copy can be frozen for lap readout while the internal count keeps running.
module stopwatch_bcd_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        div_q;
  logic        tick;
  logic        counting;
  logic [23:0] cnt_q, cnt_d, cnt_inc;
  logic [23:0] disp_q, disp_d;
  logic        running_q, running_d;
  logic        lap_q, lap_d;
  logic        wrap_q, wrap_d;
  logic [6:0]  cy;

  // Returns {carry_out, next_digit}; a digit at its limit rolls to zero and carries.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] lim,
                                          input logic cin);
    if (!cin)
      return {1'b0, d};
    if (d >= lim)
      return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  assign tick     = clk_div & ~div_q;
  assign counting = tick && (state_q == RUN);

  // Carry chain, least significant digit first; all six digits settle in one cycle.
  always_comb begin
    cy      = '0;
    cnt_inc = cnt_q;
    cy[0]   = counting;
    {cy[1], cnt_inc[3:0]}   = bcd_step(cnt_q[3:0],   4'd9, cy[0]);
    {cy[2], cnt_inc[7:4]}   = bcd_step(cnt_q[7:4],   4'd9, cy[1]);
    {cy[3], cnt_inc[11:8]}  = bcd_step(cnt_q[11:8],  4'd9, cy[2]);
    {cy[4], cnt_inc[15:12]} = bcd_step(cnt_q[15:12], 4'd5, cy[3]);
    {cy[5], cnt_inc[19:16]} = bcd_step(cnt_q[19:16], 4'd9, cy[4]);
    {cy[6], cnt_inc[23:20]} = bcd_step(cnt_q[23:20], 4'd5, cy[5]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    lap_d   = lap_q;
    wrap_d  = cy[6];
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      lap_d   = 1'b0;
      wrap_d  = 1'b0;
    end else begin
      if (start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
      if (lap) begin
        if (lap_q)
          lap_d = 1'b0;
        else if (state_q == RUN)
          lap_d = 1'b1;
      end
    end
    running_d = (state_d == RUN);
    disp_d    = lap_q ? disp_q : cnt_q;
  end

  always_ff @(posedge clk) begin
    div_q <= clk_div;
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      wrap_q    <= wrap_d;
    end
  end

  assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = disp_q;
  assign running    = running_q;
  assign lap_active = lap_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: clk_div driven by hand with a 20-cycle period,
// inputs changed and outputs sampled on the falling clock edge.
module tb_stopwatch_bcd_counter;

  logic        clk;
  logic        rst;
  logic        clk_div;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [3:0]  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
  logic        running;
  logic        lap_active;
  logic        wrap;
  logic [23:0] disp;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd_counter dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .cs_ones    (cs_ones),
    .cs_tens    (cs_tens),
    .s_ones     (s_ones),
    .s_tens     (s_tens),
    .m_ones     (m_ones),
    .m_tens     (m_tens),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  assign disp = {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_range();
    checks++;
    assert (cs_ones <= 4'd9 && cs_tens <= 4'd9 && s_ones <= 4'd9 &&
            s_tens <= 4'd5 && m_ones <= 4'd9 && m_tens <= 4'd5) else begin
      errors++;
      $error("FAIL bcd_range observed=%h expected=legal_bcd_digits", disp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One full clk_div period; optionally a start_stop pulse on the rising-edge cycle.
  task automatic tick1(input logic with_ss);
    clk_div    = 1'b1;
    start_stop = with_ss;
    @(negedge clk);
    start_stop = 1'b0;
    step(9);
    clk_div = 1'b0;
    step(10);
    chk_range();
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick1(1'b0);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_div = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_digits", disp, 24'h000000);
    check("reset_running", 24'(running), 24'd0);
    check("reset_lap", 24'(lap_active), 24'd0);
    check("reset_wrap", 24'(wrap), 24'd0);

    // Run for 123 ticks then pause
    pulse_ss();
    check("start_running", 24'(running), 24'd1);
    ticks(123);
    pulse_ss();
    check("pause_running", 24'(running), 24'd0);
    check("count_123", disp, 24'h000123);
    ticks(5);
    check("pause_holds", disp, 24'h000123);

    // Clear, lap ignored in IDLE, start_stop coincident with ticks
    pulse_clear();
    @(negedge clk);
    check("clear_digits", disp, 24'h000000);
    check("clear_running", 24'(running), 24'd0);
    pulse_lap();
    check("lap_idle_ignored", 24'(lap_active), 24'd0);
    pulse_ss();
    ticks(7);
    check("count_7", disp, 24'h000007);
    tick1(1'b1);
    check("ss_tick_run_counted", disp, 24'h000008);
    check("ss_tick_to_pause", 24'(running), 24'd0);
    pulse_lap();
    check("lap_pause_ignored", 24'(lap_active), 24'd0);
    tick1(1'b1);
    check("ss_tick_pause_not_counted", disp, 24'h000008);
    check("ss_tick_to_run", 24'(running), 24'd1);
    tick1(1'b0);
    check("count_9", disp, 24'h000009);

    // Lap freeze and release
    pulse_clear();
    @(negedge clk);
    pulse_ss();
    ticks(50);
    check("count_50", disp, 24'h000050);
    pulse_lap();
    check("lap_set", 24'(lap_active), 24'd1);
    check("lap_capture", disp, 24'h000050);
    ticks(30);
    check("lap_frozen", disp, 24'h000050);
    check("lap_still_set", 24'(lap_active), 24'd1);
    pulse_lap();
    check("lap_release", 24'(lap_active), 24'd0);
    check("lap_release_latency", disp, 24'h000050);
    @(negedge clk);
    check("lap_reload_live", disp, 24'h000080);
    pulse_lap();
    check("lap_set_again", 24'(lap_active), 24'd1);
    pulse_ss();
    pulse_lap();
    check("lap_release_in_pause", 24'(lap_active), 24'd0);
    check("pause_after_lap", 24'(running), 24'd0);

    // Preload to 59:59.98 while paused, then wrap
    force dut.cnt_q = 24'h595998;
    step(2);
    release dut.cnt_q;
    @(negedge clk);
    check("preload", disp, 24'h595998);
    pulse_ss();
    check("wrap_run", 24'(running), 24'd1);
    tick1(1'b0);
    check("count_max", disp, 24'h595999);
    check("wrap_idle", 24'(wrap), 24'd0);
    clk_div = 1'b1;
    @(negedge clk);
    check("wrap_pulse", 24'(wrap), 24'd1);
    check("wrap_running", 24'(running), 24'd1);
    check("wrap_disp_lag", disp, 24'h595999);
    @(negedge clk);
    check("wrap_one_cycle", 24'(wrap), 24'd0);
    check("wrap_zero", disp, 24'h000000);
    check("wrap_still_running", 24'(running), 24'd1);
    step(8);
    clk_div = 1'b0;
    step(10);

    // Clear beats start_stop in RUN at 00:12.34
    pulse_clear();
    @(negedge clk);
    pulse_ss();
    ticks(1234);
    check("count_1234", disp, 24'h001234);
    pulse_lap();
    check("lap_before_clear", 24'(lap_active), 24'd1);
    clear = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0; start_stop = 1'b0;
    check("clear_ss_running", 24'(running), 24'd0);
    check("clear_ss_lap", 24'(lap_active), 24'd0);
    @(negedge clk);
    check("clear_ss_digits", disp, 24'h000000);
    tick1(1'b0);
    check("idle_no_count", disp, 24'h000000);

    // Reset mid-RUN overrides start_stop and a coincident tick
    pulse_ss();
    ticks(3);
    check("count_3", disp, 24'h000003);
    pulse_lap();
    rst = 1'b1; start_stop = 1'b1; clk_div = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_stop = 1'b0;
    check("rst_run_running", 24'(running), 24'd0);
    check("rst_run_lap", 24'(lap_active), 24'd0);
    check("rst_run_digits", disp, 24'h000000);
    check("rst_run_wrap", 24'(wrap), 24'd0);
    step(9);
    clk_div = 1'b0;
    step(10);
    tick1(1'b0);
    check("rst_then_tick", disp, 24'h000000);
    check("rst_then_idle", 24'(running), 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
